sram_burst_bridge: RTL and testbench

Parametrised Wishbone-slave burst bridge for the board SRAM controller. It converts one wide block request (BEATS × DATA_W) into a sequence of single-beat SRAM strobes and gathers read beats into a wide read buffer. It also supports variable burst length and registered SRAM back-pressure. It sits between the cache/bus fabric and the SRAM controller; it is the generalised successor of the fixed 16×48 wrapper.

---
 rtl/sram_bridge_pkg.sv | 21 ++
 rtl/sram_burst_bridge_if.sv | 32 +++
 rtl/sram_beat_addr_gen.sv | 64 ++++++
 rtl/sram_burst_bridge.sv | 168 ++++++++++++++++
 tb/tb_sram_burst_bridge.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types, default parameters and slice helper for the SRAM burst bridge.
package sram_bridge_pkg;

  localparam int unsigned DATA_W_DEF    = 48;
  localparam int unsigned BEATS_DEF     = 16;
  localparam int unsigned ADDR_STEP_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    ACK
  } state_e;

  // Bit offset of beat slot inside a packed multi-beat vector.
  function automatic int unsigned beat_lsb(input int unsigned slot, input int unsigned width);
    return slot * width;
  endfunction

endpackage

// File: rtl/sram_burst_bridge_if.sv
// Block-side (ws_*) and SRAM-side (sram*) signals of the burst bridge.
interface sram_burst_bridge_if #(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned BEATS  = 16,
  parameter int unsigned DM_W   = DATA_W / 8,
  parameter int unsigned LEN_W  = $clog2(BEATS) + 1
);
  logic [31:0]             ws_addr;
  logic [LEN_W-1:0]        ws_len;
  logic [BEATS*DATA_W-1:0] ws_din;
  logic [BEATS*DM_W-1:0]   ws_dm;
  logic                    ws_stb;
  logic                    ws_we;
  logic                    ws_ack;
  logic [BEATS*DATA_W-1:0] ws_dout;
  logic [DATA_W-1:0]       sramOutData;
  logic                    sramNak;
  logic [31:0]             sramAddr;
  logic [DATA_W-1:0]       sramInData;
  logic [DM_W-1:0]         sramDm;
  logic                    sramStb;

  modport slave (
    input  ws_addr, ws_len, ws_din, ws_dm, ws_stb, ws_we, sramOutData, sramNak,
    output ws_ack, ws_dout, sramAddr, sramInData, sramDm, sramStb
  );

  modport master (
    output ws_addr, ws_len, ws_din, ws_dm, ws_stb, ws_we, sramOutData, sramNak,
    input  ws_ack, ws_dout, sramAddr, sramInData, sramDm, sramStb
  );
endinterface

// File: rtl/sram_beat_addr_gen.sv
// Beat counter, slot index and beat address; SRAM_BURST_WRAP_EN selects
// critical-word-first wrapping inside the aligned block instead of linear increment.
module sram_beat_addr_gen
  import sram_bridge_pkg::*;
#(
  parameter int unsigned BEATS     = BEATS_DEF,
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
  parameter int unsigned LEN_W     = $clog2(BEATS) + 1
) (
  input  logic                     clkCPU,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     advance,
  input  logic [31:0]              start_addr,
  output logic [31:0]              addr,
  output logic [$clog2(BEATS)-1:0] slot,
  output logic [LEN_W-1:0]         cnt,
  output logic [$clog2(BEATS)-1:0] slot_nxt_c
);
  localparam int unsigned SLOT_W = $clog2(BEATS);

  logic [31:0]       addr_nxt;
  logic [31:0]       step_addr;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [SLOT_W-1:0] start_slot;

`ifdef SRAM_BURST_WRAP_EN
  assign start_slot = SLOT_W'((start_addr / ADDR_STEP) % BEATS);
  // Stepping past the top slot folds back to the block base.
  assign step_addr  = (slot == SLOT_W'(BEATS - 1)) ? addr - 32'((BEATS - 1) * ADDR_STEP)
                                                   : addr + 32'(ADDR_STEP);
`else
  assign start_slot = '0;
  assign step_addr  = addr + 32'(ADDR_STEP);
`endif

  always_comb begin
    slot_nxt_c = slot;
    addr_nxt   = addr;
    cnt_nxt    = cnt;
    if (start) begin
      slot_nxt_c = start_slot;
      addr_nxt   = start_addr;
      cnt_nxt    = '0;
    end else if (advance) begin
      slot_nxt_c = slot + SLOT_W'(1);
      addr_nxt   = step_addr;
      cnt_nxt    = cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clkCPU or posedge rst) begin
    if (rst) begin
      addr <= '0;
      slot <= '0;
      cnt  <= '0;
    end else begin
      addr <= addr_nxt;
      slot <= slot_nxt_c;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sram_burst_bridge.sv
// Wide block request to single-beat SRAM strobes, gathering read beats into ws_dout.
// Build with SRAM_BURST_WRAP_EN for critical-word-first wrapping (length forced to BEATS).
module sram_burst_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BEATS     = BEATS_DEF,
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
  parameter int unsigned DM_W      = DATA_W / 8,
  parameter int unsigned LEN_W     = $clog2(BEATS) + 1
) (
  input logic                clkCPU,
  input logic                rst,
  sram_burst_bridge_if.slave bus
);
  localparam int unsigned SLOT_W = $clog2(BEATS);

  state_e                  state_q, state_d;
  logic [BEATS*DATA_W-1:0] din_q, buf_q;
  logic [BEATS*DM_W-1:0]   dm_q;
  logic [LEN_W-1:0]        len_q, len_d, req_len_c, cnt_c;
  logic                    ack_q, ack_d, stb_q, stb_d, pend_q, pend_d;
  logic [DM_W-1:0]         sdm_q, sdm_d;
  logic [DATA_W-1:0]       sdat_q, sdat_d;
  logic [SLOT_W-1:0]       pend_slot_q, pend_slot_d, slot_c, slot_nxt_c;
  logic [31:0]             addr_c;
  logic                    take_c, beat_acc_c, last_c, advance_c, cap_c, clr_c;

  assign take_c     = (state_q == IDLE) && bus.ws_stb && !ack_q;
  assign beat_acc_c = stb_q && !bus.sramNak;
  assign last_c     = (cnt_c == len_q - LEN_W'(1));
  assign advance_c  = beat_acc_c && !last_c;

`ifdef SRAM_BURST_WRAP_EN
  assign req_len_c = LEN_W'(BEATS);
`else
  assign req_len_c = (bus.ws_len == '0) ? LEN_W'(BEATS) : bus.ws_len;
`endif

  sram_beat_addr_gen #(
    .BEATS    (BEATS),
    .ADDR_STEP(ADDR_STEP),
    .LEN_W    (LEN_W)
  ) u_addr_gen (
    .clkCPU    (clkCPU),
    .rst       (rst),
    .start     (take_c),
    .advance   (advance_c),
    .start_addr(bus.ws_addr),
    .addr      (addr_c),
    .slot      (slot_c),
    .cnt       (cnt_c),
    .slot_nxt_c(slot_nxt_c)
  );

  // Read data for an accepted beat is captured one non-stalled edge later (pend_*).
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    stb_d       = stb_q;
    sdm_d       = sdm_q;
    sdat_d      = sdat_q;
    len_d       = len_q;
    pend_d      = pend_q;
    pend_slot_d = pend_slot_q;
    cap_c       = 1'b0;
    clr_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take_c) begin
          stb_d  = 1'b1;
          len_d  = req_len_c;
          pend_d = 1'b0;
          if (bus.ws_we) begin
            state_d = WRITE;
            sdat_d  = bus.ws_din[beat_lsb(32'(slot_nxt_c), DATA_W) +: DATA_W];
            sdm_d   = bus.ws_dm[beat_lsb(32'(slot_nxt_c), DM_W) +: DM_W];
          end else begin
            state_d = READ;
            sdat_d  = '0;
            sdm_d   = '0;
            clr_c   = 1'b1;
          end
        end
      end
      WRITE: begin
        if (beat_acc_c) begin
          if (last_c) begin
            stb_d   = 1'b0;
            sdm_d   = '0;
            ack_d   = 1'b1;
            state_d = ACK;
          end else begin
            sdat_d = din_q[beat_lsb(32'(slot_nxt_c), DATA_W) +: DATA_W];
            sdm_d  = dm_q[beat_lsb(32'(slot_nxt_c), DM_W) +: DM_W];
          end
        end
      end
      READ: begin
        if (!bus.sramNak) begin
          cap_c       = pend_q;
          pend_d      = stb_q;
          pend_slot_d = slot_c;
          if (stb_q && last_c) begin
            stb_d   = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!bus.sramNak) begin
          cap_c   = pend_q;
          pend_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkCPU or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      stb_q       <= 1'b0;
      sdm_q       <= '0;
      sdat_q      <= '0;
      len_q       <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      din_q       <= '0;
      dm_q        <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      stb_q       <= stb_d;
      sdm_q       <= sdm_d;
      sdat_q      <= sdat_d;
      len_q       <= len_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      if (take_c) begin
        din_q <= bus.ws_din;
        dm_q  <= bus.ws_dm;
      end
    end
  end

  always_ff @(posedge clkCPU or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (clr_c) begin
      buf_q <= '0;
    end else if (cap_c) begin
      buf_q[beat_lsb(32'(pend_slot_q), DATA_W) +: DATA_W] <= bus.sramOutData;
    end
  end

  assign bus.ws_ack     = ack_q;
  assign bus.ws_dout    = buf_q;
  assign bus.sramAddr   = addr_c;
  assign bus.sramInData = sdat_q;
  assign bus.sramDm     = sdm_q;
  assign bus.sramStb    = stb_q;

endmodule

// File: tb/tb_sram_burst_bridge.sv
// Directed bench for sram_burst_bridge with an expected-beat scoreboard and SRAM model.
module tb_sram_burst_bridge;
  import sram_bridge_pkg::*;

  localparam int unsigned DW   = DATA_W_DEF;
  localparam int unsigned NB   = BEATS_DEF;
  localparam int unsigned STEP = ADDR_STEP_DEF;
  localparam int unsigned DMW  = DW / 8;
  localparam int unsigned LW   = $clog2(NB) + 1;

  typedef struct {
    logic [31:0]    a;
    logic [DW-1:0]  d;
    logic [DMW-1:0] m;
    int             s;
  } beat_t;

  logic  clkCPU = 1'b0;
  logic  rst    = 1'b1;
  int    errors = 0;
  int    checks = 0;
  int    obs_rd = 0;
  int    lat;
  beat_t exp_q[$];
  beat_t obs_q[$];

  sram_burst_bridge_if #(.DATA_W(DW), .BEATS(NB)) bus ();

  sram_burst_bridge #(.DATA_W(DW), .BEATS(NB), .ADDR_STEP(STEP)) dut (
    .clkCPU(clkCPU),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clkCPU = ~clkCPU;

  function automatic logic [DW-1:0] rd_val(input logic [31:0] a);
    return 48'h0000_1234_5600 + DW'(a >> 2);
  endfunction

  function automatic int slot_of(input logic [31:0] base, input int k);
`ifdef SRAM_BURST_WRAP_EN
    return int'((base / STEP + 32'(k)) % NB);
`else
    return k;
`endif
  endfunction

  function automatic logic [31:0] addr_of(input logic [31:0] base, input int k);
`ifdef SRAM_BURST_WRAP_EN
    return (base & ~32'(NB * STEP - 1)) + 32'(slot_of(base, k) * STEP);
`else
    return base + 32'(k * STEP);
`endif
  endfunction

  function automatic int eff_len(input int len);
`ifdef SRAM_BURST_WRAP_EN
    return NB;
`else
    return (len == 0) ? NB : len;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM model: records accepted beats, returns data for the accepted address, junk otherwise.
  always @(posedge clkCPU) begin
    logic        acc;
    logic        stall;
    logic [31:0] a;
    acc   = !rst && bus.sramStb && !bus.sramNak;
    stall = bus.sramNak;
    a     = bus.sramAddr;
    if (acc) obs_q.push_back('{a: a, d: bus.sramInData, m: bus.sramDm, s: 0});
    #1;
    if (!stall) bus.sramOutData = acc ? rd_val(a) : 48'hBAD0_BAD0_BAD0;
  end

  task automatic push_exp(input logic we, input logic [31:0] addr, input int len);
    for (int k = 0; k < eff_len(len); k++) begin
      beat_t b;
      int    s;
      s   = slot_of(addr, k);
      b.a = addr_of(addr, k);
      b.s = s;
      b.d = we ? bus.ws_din[s*DW +: DW] : '0;
      b.m = we ? bus.ws_dm[s*DMW +: DMW] : '0;
      exp_q.push_back(b);
    end
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr, input int len,
                           input logic rnd_mask, input logic hold);
    logic [NB*DW-1:0]  din;
    logic [NB*DMW-1:0] dm;
    @(negedge clkCPU);
    for (int k = 0; k < NB; k++) begin
      din[k*DW +: DW]   = DW'({$urandom(), $urandom()});
      dm[k*DMW +: DMW]  = !we ? '0 : rnd_mask ? DMW'($urandom_range(1, 63)) : DMW'(6'h3F);
    end
    bus.ws_we   = we;
    bus.ws_addr = addr;
    bus.ws_len  = LW'(len);
    bus.ws_din  = din;
    bus.ws_dm   = dm;
    bus.ws_stb  = 1'b1;
    push_exp(we, addr, len);
    @(posedge clkCPU); #1;
    chk("accept_stb", 64'(bus.sramStb), 64'(1));
    chk("accept_addr", 64'(bus.sramAddr), 64'(exp_q[0].a));
    if (!hold) bus.ws_stb = 1'b0;
  endtask

  // Counts edges after accept until ws_ack; stalls edges [stall_at, stall_at+stall_n).
  task automatic wait_ack(input int stall_at, input int stall_n, output int l);
    int acc;
    bit got;
    acc = 0;
    got = 0;
    l   = -1;
    for (int n = 1; n <= 300 && !got; n++) begin
      bit st;
      @(negedge clkCPU);
      st = (n >= stall_at) && (n < stall_at + stall_n);
      bus.sramNak = st;
      @(posedge clkCPU); #1;
      if (st && acc < exp_q.size()) begin
        chk("stall_stb", 64'(bus.sramStb), 64'(1));
        chk("stall_addr", 64'(bus.sramAddr), 64'(exp_q[acc].a));
      end else if (!st && acc < exp_q.size()) begin
        acc++;
      end
      if (bus.ws_ack === 1'b1) begin
        got = 1;
        l   = n;
      end
    end
    bus.sramNak = 1'b0;
    chk("ack_cycle_stb", 64'(bus.sramStb), 64'(0));
  endtask

  task automatic compare_beats(input logic we);
    logic [DW-1:0] e [NB];
    chk("beat_count", 64'(obs_q.size() - obs_rd), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && obs_rd + k < obs_q.size(); k++) begin
      chk($sformatf("beat%0d_addr", k), 64'(obs_q[obs_rd+k].a), 64'(exp_q[k].a));
      chk($sformatf("beat%0d_dm", k), 64'(obs_q[obs_rd+k].m), 64'(exp_q[k].m));
      if (we) chk($sformatf("beat%0d_data", k), 64'(obs_q[obs_rd+k].d), 64'(exp_q[k].d));
    end
    if (!we) begin
      for (int i = 0; i < NB; i++) e[i] = '0;
      foreach (exp_q[k]) e[exp_q[k].s] = rd_val(exp_q[k].a);
      for (int i = 0; i < NB; i++)
        chk($sformatf("dout_slot%0d", i), 64'(bus.ws_dout[i*DW +: DW]), 64'(e[i]));
    end
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  task automatic post_ack;
    @(posedge clkCPU); #1;
    chk("ack_single_pulse", 64'(bus.ws_ack), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.ws_addr = '0;
    bus.ws_len  = '0;
    bus.ws_din  = '0;
    bus.ws_dm   = '0;
    bus.ws_stb  = 1'b0;
    bus.ws_we   = 1'b0;
    bus.sramNak = 1'b0;

    // Reset state
    #12;
    chk("rst_ack", 64'(bus.ws_ack), 64'(0));
    chk("rst_stb", 64'(bus.sramStb), 64'(0));
    chk("rst_addr", 64'(bus.sramAddr), 64'(0));
    chk("rst_dm", 64'(bus.sramDm), 64'(0));
    chk("rst_indata", 64'(bus.sramInData), 64'(0));
    chk("rst_dout_any", 64'(|bus.ws_dout), 64'(0));
    @(negedge clkCPU) rst = 1'b0;

    // Full write burst, mask 0x3F
    start_req(1'b1, 32'h100, 16, 1'b0, 1'b0);
    wait_ack(0, 0, lat);
    chk("wr16_latency", 64'(lat), 64'(eff_len(16)));
    compare_beats(1'b1);
    post_ack();

    // Full read burst from 0
    start_req(1'b0, 32'h0, 16, 1'b0, 1'b0);
    wait_ack(0, 0, lat);
    chk("rd16_latency", 64'(lat), 64'(eff_len(16) + 1));
    compare_beats(1'b0);
    post_ack();

    // Short read with a 3-cycle stall after the first beat
    start_req(1'b0, 32'h40, 4, 1'b0, 1'b0);
    wait_ack(2, 3, lat);
    chk("rd4_stall_latency", 64'(lat), 64'(eff_len(4) + 1 + 3));
    compare_beats(1'b0);
    post_ack();

    // Short write wrapping through 0xFFFFFFFF, random masks
    start_req(1'b1, 32'hFFFF_FFF8, 3, 1'b1, 1'b0);
    wait_ack(0, 0, lat);
    chk("wr3_wrap32_latency", 64'(lat), 64'(eff_len(3)));
    compare_beats(1'b1);
    post_ack();

    // Length 0 means a full burst
    start_req(1'b0, 32'h800, 0, 1'b0, 1'b0);
    wait_ack(0, 0, lat);
    chk("rd0_latency", 64'(lat), 64'(eff_len(0) + 1));
    compare_beats(1'b0);
    post_ack();

    // ws_stb held high across ws_ack: one take per ack
    start_req(1'b0, 32'h200, 2, 1'b0, 1'b1);
    wait_ack(0, 0, lat);
    chk("hold1_latency", 64'(lat), 64'(eff_len(2) + 1));
    compare_beats(1'b0);
    push_exp(1'b0, 32'h200, 2);
    @(posedge clkCPU); #1;
    chk("hold_idle_stb", 64'(bus.sramStb), 64'(0));
    chk("hold_idle_ack", 64'(bus.ws_ack), 64'(0));
    @(posedge clkCPU); #1;
    chk("hold_retake_stb", 64'(bus.sramStb), 64'(1));
    chk("hold_retake_addr", 64'(bus.sramAddr), 64'(exp_q[0].a));
    bus.ws_stb = 1'b0;
    wait_ack(0, 0, lat);
    chk("hold2_latency", 64'(lat), 64'(eff_len(2) + 1));
    compare_beats(1'b0);
    post_ack();
    @(posedge clkCPU); #1;
    chk("hold_no_third_take", 64'(bus.sramStb), 64'(0));

    // Reset mid-read while beat 5 is presented
    start_req(1'b0, 32'h300, 16, 1'b0, 1'b0);
    repeat (5) @(posedge clkCPU);
    #1;
    chk("beat5_presented", 64'(bus.sramAddr), 64'(exp_q[5].a));
    #2 rst = 1'b1;
    #1;
    chk("midrst_ack", 64'(bus.ws_ack), 64'(0));
    chk("midrst_stb", 64'(bus.sramStb), 64'(0));
    chk("midrst_addr", 64'(bus.sramAddr), 64'(0));
    chk("midrst_dm", 64'(bus.sramDm), 64'(0));
    chk("midrst_indata", 64'(bus.sramInData), 64'(0));
    chk("midrst_dout_any", 64'(|bus.ws_dout), 64'(0));
    repeat (2) @(posedge clkCPU);
    #1;
    chk("midrst_no_ack", 64'(bus.ws_ack), 64'(0));
    @(negedge clkCPU) rst = 1'b0;
    exp_q.delete();
    obs_rd = obs_q.size();
    start_req(1'b0, 32'h10, 2, 1'b0, 1'b0);
    wait_ack(0, 0, lat);
    chk("after_rst_latency", 64'(lat), 64'(eff_len(2) + 1));
    compare_beats(1'b0);
    post_ack();

`ifdef SRAM_BURST_WRAP_EN
    // Critical-word-first read starting at 0x38
    start_req(1'b0, 32'h38, 16, 1'b0, 1'b0);
    wait_ack(0, 0, lat);
    chk("wrap_latency", 64'(lat), 64'(NB + 1));
    chk("wrap_first_addr", 64'(obs_q[obs_rd].a), 64'(32'h38));
    chk("wrap_third_addr", 64'(obs_q[obs_rd+2].a), 64'(32'h00));
    chk("wrap_slot0", 64'(bus.ws_dout[0 +: DW]), 64'(rd_val(32'h0)));
    compare_beats(1'b0);
    post_ack();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
